// File: rtl/hyper_txn_sched.sv
// hyper_txn_sched: round-robin scheduler turning requester commands into HyperBus uDMA cfg-register writes.
// Define HYPER_SCHED_TIMEOUT_EN to add the WAIT_EOT watchdog with CLR write and error pulse.
module hyper_txn_sched #(
    parameter int NB_REQ         = 2,
    parameter int L2_AWIDTH_NOAL = 19,
    parameter int TRANS_SIZE     = 20,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int PW            = $clog2(NB_REQ)
) (
    input  logic                                  sys_clk_i,
    input  logic                                  rst_i,
    input  logic [NB_REQ-1:0]                     req_valid_i,
    output logic [NB_REQ-1:0]                     req_ready_o,
    input  logic [NB_REQ-1:0]                     req_rd_i,
    input  logic [NB_REQ-1:0][31:0]               req_ext_addr_i,
    input  logic [NB_REQ-1:0][L2_AWIDTH_NOAL-1:0] req_l2_addr_i,
    input  logic [NB_REQ-1:0][TRANS_SIZE-1:0]     req_size_i,
    output logic [NB_REQ-1:0]                     req_done_o,
    output logic [NB_REQ-1:0]                     req_err_o,
    output logic                                  cfg_valid_o,
    output logic [4:0]                            cfg_addr_o,
    output logic [31:0]                           cfg_data_o,
    output logic                                  cfg_rwn_o,
    input  logic                                  cfg_ready_i,
    input  logic                                  evt_eot_i,
    output logic                                  busy_o,
    output logic [PW-1:0]                         cur_req_o
);

    if (NB_REQ < 2 || NB_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_chk
        $error("hyper_txn_sched: NB_REQ or TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_W_EXT    = 4'd1,
        S_W_SADDR  = 4'd2,
        S_W_SIZE   = 4'd3,
        S_W_CFG    = 4'd4,
        S_WAIT_EOT = 4'd5,
        S_DONE     = 4'd6
`ifdef HYPER_SCHED_TIMEOUT_EN
        ,
        S_W_CLR    = 4'd7,
        S_ERR      = 4'd8
`endif
    } state_e;

    state_e                    state_q, state_d;
    logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]             cur_q, cur_d;
    logic                      rd_q, rd_d;
    logic [31:0]               ext_q, ext_d;
    logic [L2_AWIDTH_NOAL-1:0] l2_q, l2_d;
    logic [TRANS_SIZE-1:0]     size_q, size_d;
`ifdef HYPER_SCHED_TIMEOUT_EN
    logic [15:0]               cnt_q, cnt_d;
`endif

    logic [NB_REQ-1:0] grant_s;
    logic [PW-1:0]     gidx_s;
    logic              any_s;
    logic [NB_REQ-1:0] ready_s, done_s, err_s;
    logic              cfg_valid_s;
    logic [4:0]        cfg_addr_s;
    logic [31:0]       cfg_data_s;

    // Round-robin search for the first valid requester at or after rr_ptr_q
    always_comb begin
        int idx_v;
        idx_v   = 0;
        grant_s = '0;
        gidx_s  = '0;
        any_s   = 1'b0;
        for (int i = 0; i < NB_REQ; i++) begin
            idx_v = int'(rr_ptr_q) + i;
            if (idx_v >= NB_REQ) begin
                idx_v = idx_v - NB_REQ;
            end else begin
                idx_v = idx_v;
            end
            if (!any_s && req_valid_i[PW'(idx_v)]) begin
                any_s  = 1'b1;
                gidx_s = PW'(idx_v);
            end else begin
                any_s  = any_s;
            end
        end
        if (any_s) begin
            grant_s[gidx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Next-state, capture and cfg-port decode
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_d       = cur_q;
        rd_d        = rd_q;
        ext_d       = ext_q;
        l2_d        = l2_q;
        size_d      = size_q;
`ifdef HYPER_SCHED_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        ready_s     = '0;
        done_s      = '0;
        err_s       = '0;
        cfg_valid_s = 1'b0;
        cfg_addr_s  = 5'h00;
        cfg_data_s  = 32'h0000_0000;
        case (state_q)
            S_IDLE: begin
                ready_s = grant_s;
                if (any_s) begin
                    cur_d  = gidx_s;
                    rd_d   = req_rd_i[gidx_s];
                    ext_d  = req_ext_addr_i[gidx_s];
                    l2_d   = req_l2_addr_i[gidx_s];
                    size_d = req_size_i[gidx_s];
                    if (gidx_s == PW'(NB_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = gidx_s + PW'(1);
                    end
                    // Zero-length commands complete without touching the controller
                    if (req_size_i[gidx_s] == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_W_EXT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_W_EXT: begin
                cfg_valid_s = 1'b1;
                cfg_addr_s  = 5'h08;
                cfg_data_s  = ext_q;
                state_d     = cfg_ready_i ? S_W_SADDR : S_W_EXT;
            end
            S_W_SADDR: begin
                cfg_valid_s = 1'b1;
                cfg_addr_s  = rd_q ? 5'h00 : 5'h04;
                cfg_data_s  = 32'(l2_q);
                state_d     = cfg_ready_i ? S_W_SIZE : S_W_SADDR;
            end
            S_W_SIZE: begin
                cfg_valid_s = 1'b1;
                cfg_addr_s  = rd_q ? 5'h01 : 5'h05;
                cfg_data_s  = 32'(size_q);
                state_d     = cfg_ready_i ? S_W_CFG : S_W_SIZE;
            end
            S_W_CFG: begin
                cfg_valid_s = 1'b1;
                cfg_addr_s  = rd_q ? 5'h02 : 5'h06;
                cfg_data_s  = 32'h0000_0010;
`ifdef HYPER_SCHED_TIMEOUT_EN
                cnt_d       = 16'h0000;
`endif
                state_d     = cfg_ready_i ? S_WAIT_EOT : S_W_CFG;
            end
            S_WAIT_EOT: begin
                if (evt_eot_i) begin
                    state_d = S_DONE;
`ifdef HYPER_SCHED_TIMEOUT_EN
                end else if (cnt_q == 16'(TIMEOUT_CYCLES)) begin
                    state_d = S_W_CLR;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_WAIT_EOT;
`else
                end else begin
                    state_d = S_WAIT_EOT;
`endif
                end
            end
            S_DONE: begin
                done_s[cur_q] = 1'b1;
                state_d       = S_IDLE;
            end
`ifdef HYPER_SCHED_TIMEOUT_EN
            S_W_CLR: begin
                cfg_valid_s = 1'b1;
                cfg_addr_s  = rd_q ? 5'h02 : 5'h06;
                cfg_data_s  = 32'h0000_0020;
                state_d     = cfg_ready_i ? S_ERR : S_W_CLR;
            end
            S_ERR: begin
                err_s[cur_q] = 1'b1;
                state_d      = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and captured-command registers
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            cur_q    <= '0;
            rd_q     <= 1'b0;
            ext_q    <= 32'h0000_0000;
            l2_q     <= '0;
            size_q   <= '0;
`ifdef HYPER_SCHED_TIMEOUT_EN
            cnt_q    <= 16'h0000;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cur_q    <= cur_d;
            rd_q     <= rd_d;
            ext_q    <= ext_d;
            l2_q     <= l2_d;
            size_q   <= size_d;
`ifdef HYPER_SCHED_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign req_ready_o = ready_s;
    assign req_done_o  = done_s;
`ifdef HYPER_SCHED_TIMEOUT_EN
    assign req_err_o   = err_s;
`else
    assign req_err_o   = err_s & {NB_REQ{1'b0}};
`endif
    assign cfg_valid_o = cfg_valid_s;
    assign cfg_addr_o  = cfg_addr_s;
    assign cfg_data_o  = cfg_data_s;
    assign cfg_rwn_o   = 1'b0;
    assign busy_o      = (state_q != S_IDLE);
    assign cur_req_o   = cur_q;

endmodule

// File: tb/tb_hyper_txn_sched.sv
// Directed, table-driven bench for hyper_txn_sched (default build, two requesters).
module tb_hyper_txn_sched;
    localparam int NB_REQ = 2;
    localparam int L2W    = 19;
    localparam int SW     = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst;
    logic [NB_REQ-1:0]          req_valid, req_ready, req_rd, req_done, req_err;
    logic [NB_REQ-1:0][31:0]    req_ext;
    logic [NB_REQ-1:0][L2W-1:0] req_l2;
    logic [NB_REQ-1:0][SW-1:0]  req_size;
    logic                       cfg_valid, cfg_rwn, cfg_ready, eot, busy;
    logic [4:0]                 cfg_addr;
    logic [31:0]                cfg_data;
    logic [0:0]                 cur_req;

    hyper_txn_sched #(.NB_REQ(NB_REQ), .L2_AWIDTH_NOAL(L2W), .TRANS_SIZE(SW), .TIMEOUT_CYCLES(16)) dut (
        .sys_clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rd_i(req_rd),
        .req_ext_addr_i(req_ext), .req_l2_addr_i(req_l2), .req_size_i(req_size),
        .req_done_o(req_done), .req_err_o(req_err),
        .cfg_valid_o(cfg_valid), .cfg_addr_o(cfg_addr), .cfg_data_o(cfg_data),
        .cfg_rwn_o(cfg_rwn), .cfg_ready_i(cfg_ready), .evt_eot_i(eot),
        .busy_o(busy), .cur_req_o(cur_req)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  val;
        logic        crdy;
        logic        eot;
        logic [1:0]  e_rdy;
        logic        e_cv;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [1:0]  e_done;
        logic        e_busy;
        logic        e_cur;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic [1:0] v, input logic cr, input logic ev,
                       input logic [1:0] erdy, input logic ecv, input logic [4:0] ea,
                       input logic [31:0] ed, input logic [1:0] edone, input logic eb, input logic ec);
        vec_t t;
        t.rst = r; t.val = v; t.crdy = cr; t.eot = ev;
        t.e_rdy = erdy; t.e_cv = ecv; t.e_addr = ea; t.e_data = ed;
        t.e_done = edone; t.e_busy = eb; t.e_cur = ec;
        vecs.push_back(t);
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst       = vecs[i].rst;
            req_valid = vecs[i].val;
            cfg_ready = vecs[i].crdy;
            eot       = vecs[i].eot;
            @(negedge clk);
            checks++;
            if (req_ready !== vecs[i].e_rdy || cfg_valid !== vecs[i].e_cv ||
                cfg_addr !== vecs[i].e_addr || cfg_data !== vecs[i].e_data ||
                req_done !== vecs[i].e_done || busy !== vecs[i].e_busy ||
                cur_req !== vecs[i].e_cur || req_err !== 2'b00 || cfg_rwn !== 1'b0) begin
                errors++;
                $display("FAIL %s[%0d]: got rdy=%b cv=%b addr=%h data=%h done=%b err=%b busy=%b cur=%0d rwn=%b; want rdy=%b cv=%b addr=%h data=%h done=%b err=00 busy=%b cur=%0d rwn=0",
                         tag, i, req_ready, cfg_valid, cfg_addr, cfg_data, req_done, req_err, busy, cur_req, cfg_rwn,
                         vecs[i].e_rdy, vecs[i].e_cv, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_done,
                         vecs[i].e_busy, vecs[i].e_cur);
            end
        end
        vecs.delete();
    endtask

    task automatic set_req(input int r, input logic rd, input logic [31:0] ext,
                           input logic [L2W-1:0] l2, input logic [SW-1:0] sz);
        req_rd[r]   = rd;
        req_ext[r]  = ext;
        req_l2[r]   = l2;
        req_size[r] = sz;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; cfg_ready = 1'b1; eot = 1'b0;
        req_rd = 2'b00; req_ext = '0; req_l2 = '0; req_size = '0;
        set_req(0, 1'b1, 32'h0000_1000, 19'h00400, 20'd64);
        set_req(1, 1'b0, 32'hA000_0040, 19'h7FFFF, 20'hFFFFF);
        repeat (3) @(posedge clk);

        // Reset state, then single read on r0 with eot at cycle 10
        add(1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 5'h00, 32'h0, 2'b00, 1'b0, 1'b0);
        add(1'b0, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 5'h00, 32'h0, 2'b00, 1'b0, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 5'h08, 32'h0000_1000, 2'b00, 1'b1, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 5'h00, 32'h0000_0400, 2'b00, 1'b1, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 5'h01, 32'h0000_0040, 2'b00, 1'b1, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 5'h02, 32'h0000_0010, 2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++)
            add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 5'h00, 32'h0, 2'b00, 1'b1, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 5'h00, 32'h0, 2'b00, 1'b1, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 5'h00, 32'h0, 2'b01, 1'b1, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 5'h00, 32'h0, 2'b00, 1'b0, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 5'h00, 32'h0, 2'b00, 1'b0, 1'b0);
        run_vecs("read_r0");

        // Write on r1: max l2/size values, spurious eot in W_SADDR, 3-cycle stall in W_SIZE
        add(1'b0, 2'b10, 1'b1, 1'b0, 2'b10, 1'b0, 5'h00, 32'h0, 2'b00, 1'b0, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 5'h08, 32'hA000_0040, 2'b00, 1'b1, 1'b1);
        add(1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 5'h04, 32'h0007_FFFF, 2'b00, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++)
            add(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 5'h05, 32'h000F_FFFF, 2'b00, 1'b1, 1'b1);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 5'h05, 32'h000F_FFFF, 2'b00, 1'b1, 1'b1);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 5'h06, 32'h0000_0010, 2'b00, 1'b1, 1'b1);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 5'h00, 32'h0, 2'b00, 1'b1, 1'b1);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 5'h00, 32'h0, 2'b00, 1'b1, 1'b1);
        add(1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 5'h00, 32'h0, 2'b00, 1'b1, 1'b1);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 5'h00, 32'h0, 2'b10, 1'b1, 1'b1);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 5'h00, 32'h0, 2'b00, 1'b0, 1'b1);
        run_vecs("write_r1_stall");

        // Both requesters valid with size 0: grants alternate, two-cycle spacing, no cfg writes
        set_req(0, 1'b1, 32'h0000_1000, 19'h00400, 20'd0);
        set_req(1, 1'b0, 32'hA000_0040, 19'h7FFFF, 20'd0);
        for (int k = 0; k < 2; k++) begin
            add(1'b0, 2'b11, 1'b1, 1'b0, 2'b01, 1'b0, 5'h00, 32'h0, 2'b00, 1'b0, 1'b1);
            add(1'b0, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 5'h00, 32'h0, 2'b01, 1'b1, 1'b0);
            add(1'b0, 2'b11, 1'b1, 1'b0, 2'b10, 1'b0, 5'h00, 32'h0, 2'b00, 1'b0, 1'b0);
            add(1'b0, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 5'h00, 32'h0, 2'b10, 1'b1, 1'b1);
        end
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 5'h00, 32'h0, 2'b00, 1'b0, 1'b1);
        // Pointer at r0 but only r1 valid: r1 is granted, done one cycle later
        add(1'b0, 2'b10, 1'b1, 1'b0, 2'b10, 1'b0, 5'h00, 32'h0, 2'b00, 1'b0, 1'b1);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 5'h00, 32'h0, 2'b10, 1'b1, 1'b1);
        run_vecs("alternate_size0");

        // Reset while in WAIT_EOT: abort to IDLE, no done, round-robin pointer back to r0
        set_req(0, 1'b1, 32'h0000_1000, 19'h00400, 20'd64);
        set_req(1, 1'b0, 32'hA000_0040, 19'h7FFFF, 20'd8);
        add(1'b0, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 5'h00, 32'h0, 2'b00, 1'b0, 1'b1);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 5'h08, 32'h0000_1000, 2'b00, 1'b1, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 5'h00, 32'h0000_0400, 2'b00, 1'b1, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 5'h01, 32'h0000_0040, 2'b00, 1'b1, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 5'h02, 32'h0000_0010, 2'b00, 1'b1, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 5'h00, 32'h0, 2'b00, 1'b1, 1'b0);
        add(1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 5'h00, 32'h0, 2'b00, 1'b1, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 5'h00, 32'h0, 2'b00, 1'b0, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 5'h00, 32'h0, 2'b00, 1'b0, 1'b0);
        add(1'b0, 2'b11, 1'b1, 1'b0, 2'b01, 1'b0, 5'h00, 32'h0, 2'b00, 1'b0, 1'b0);
        add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 5'h08, 32'h0000_1000, 2'b00, 1'b1, 1'b0);
        run_vecs("reset_in_wait");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
